decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered ID stage of the 5-stage RV32I pipeline. Generalised successor to the combinational control decoder.
- Decodes the full RV32I integer subset into a control bundle and produces the sign-extended XLEN immediate.
- Registers decoded results into the ID/EX pipeline register with a valid/ready handshake.
- Detects load-use hazards (inserts a bubble), honours branch flush, and counts stall cycles.

Parameters:
XLEN, 32, datapath/PC/immediate width (32 or 64)
ALUSEL_W, 4, ALU select width (widened from 3 to add SLT/SLTU)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc  in  XLEN  PC of if_instr
id_ready  out  1  stage accepts if_instr this cycle
flush  in  1  squash ID and ID/EX contents (taken branch/jump from EX)
ex_ready  in  1  EX stage accepts ID/EX contents
ex_valid  out  1  ID/EX register valid
ex_pc  out  XLEN  registered PC
ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
ex_imm  out  XLEN  sign-extended immediate
ex_alusel  out  ALUSEL_W  ALU operation
ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jalr, ex_illegal  out  1 each  control flags
stall_cnt  out  CNT_W  load-use bubbles inserted since reset (saturating)

Behaviour:
- Reset (rst_n=0 at posedge):
  - All ex_* = 0, stall_cnt = 0.
  - id_ready is combinational; it evaluates to 1 while ex_valid=0 and flush=0.
- ALU select encoding:
  - ADD 0000, SLL 0001, SUB 0010, SRA 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SLT 1000, SLTU 1001.
  - R-type selects by funct3 plus funct7[5]. Note SRL=0101 and SRA=0011.
  - I-ALU (0010011) uses the same map. SUB is never produced by I-ALU. SRAI is selected by instr[30].
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
  - All sign-extended from instr[31] to XLEN. R-type imm = 0.
- Opcode behaviour:
  - LOAD: mem_read=1, reg_write=1, ALU ADD, use_imm=1.
  - STORE: mem_write=1, reg_write=0, ALU ADD, use_imm=1.
  - BRANCH: branch=1, ALU SUB, reg_write=0.
  - JAL: jump=1, reg_write=1.
  - JALR: jump=1, jalr=1, use_imm=1, reg_write=1.
  - LUI/AUIPC: reg_write=1, use_imm=1, ALU ADD.
  - Any other opcode, or an invalid funct3/funct7: illegal=1, with all write/mem/branch/jump flags = 0.
- rd == 0 forces reg_write=0.
- Operand usage:
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by R, STORE, BRANCH.
- Load-use hazard (combinational): hazard = if_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((use_rs1 & rs1 == ex_rd) | (use_rs2 & rs2 == ex_rd)).
- id_ready = (ex_ready | ~ex_valid) & ~hazard & ~flush.
- ID/EX update occurs on each posedge where ex_ready | ~ex_valid. Priority order:
  1. flush → ex_valid=0.
  2. hazard → ex_valid=0 (bubble), stall_cnt += 1 (saturating at all-ones).
  3. if_valid → load decoded bundle, ex_valid=1.
  4. otherwise → ex_valid=0.
- When no update occurs (ex_valid=1 & ~ex_ready), all ex_* hold. The exception is flush, which clears ex_valid regardless of ex_ready.
- Bubbles clear ex_valid only. Other ex_* fields are don't-care but must not assert mem_write/reg_write with ex_valid=1.
- A hazard persists exactly one cycle per load: after the bubble, ex_mem_read is 0, so the instruction is accepted next cycle.
- Latency: one cycle from if_valid&id_ready to ex_valid.
- Reset mid-stream drops the in-flight bundle; there is no replay.

Decomposition:
- decode_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ALUSEL_* encodings;
  - the ctrl_t struct (all ex_* flags plus alusel);
  - the imm_fmt_t enum.
- Sub-module decode_comb: purely combinational, inputs instr, outputs ctrl_t, imm, use_rs1, use_rs2.
- decode_stage holds the hazard logic, handshake, ID/EX register and counter.

Test Plan:
- add x3,x1,x2 (0x002081B3), ex_ready=1 → next cycle ex_valid=1, alusel=0000, rd=3, reg_write=1, imm=0.
- lw x5,8(x1) (0x0080A283), then add x6,x5,x2 (0x00228333) → one bubble (ex_valid=0 for one cycle, id_ready=0), stall_cnt=1, then the add is issued.
- sw x2,-4(x1) (0xFE20AE23) → mem_write=1, reg_write=0, ex_imm=0xFFFFFFFC.
- beq x0,x0,-8 (0xFE000CE3) → branch=1, alusel=0010, imm=0xFFFFFFF8. Same instruction with XLEN=64 → imm=0xFFFFFFFFFFFFFFF8.
- ex_ready=0 held for 3 cycles with ex_valid=1 → all ex_* stable, id_ready=0. Asserting flush in cycle 2 → ex_valid=0 next cycle.
- Opcode 0x7F, and add with rd=0 → illegal=1 with all flags 0; the rd=0 case gives reg_write=0. Reset with rst_n=0 mid-stream → ex_valid=0 and stall_cnt=0 after the edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU select codes,
// the decoded control bundle and the immediate format selector.
package decode_pkg;

   localparam int ALU_W = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [ALU_W-1:0] ALUSEL_ADD  = 4'b0000;
   localparam logic [ALU_W-1:0] ALUSEL_SLL  = 4'b0001;
   localparam logic [ALU_W-1:0] ALUSEL_SUB  = 4'b0010;
   localparam logic [ALU_W-1:0] ALUSEL_SRA  = 4'b0011;
   localparam logic [ALU_W-1:0] ALUSEL_XOR  = 4'b0100;
   localparam logic [ALU_W-1:0] ALUSEL_SRL  = 4'b0101;
   localparam logic [ALU_W-1:0] ALUSEL_OR   = 4'b0110;
   localparam logic [ALU_W-1:0] ALUSEL_AND  = 4'b0111;
   localparam logic [ALU_W-1:0] ALUSEL_SLT  = 4'b1000;
   localparam logic [ALU_W-1:0] ALUSEL_SLTU = 4'b1001;

   typedef struct packed {
      logic [ALU_W-1:0] alusel;
      logic             use_imm;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             jalr;
      logic             illegal;
   } ctrl_t;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
   } imm_fmt_t;

   // alt is funct7[5] for R-type; I-type callers pass it only for shifts.
   function automatic logic [ALU_W-1:0] alu_sel(input logic [2:0] funct3, input logic alt);
      logic [ALU_W-1:0] sel;
      case (funct3)
         3'b000:  sel = alt ? ALUSEL_SUB : ALUSEL_ADD;
         3'b001:  sel = ALUSEL_SLL;
         3'b010:  sel = ALUSEL_SLT;
         3'b011:  sel = ALUSEL_SLTU;
         3'b100:  sel = ALUSEL_XOR;
         3'b101:  sel = alt ? ALUSEL_SRA : ALUSEL_SRL;
         3'b110:  sel = ALUSEL_OR;
         default: sel = ALUSEL_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID-side and ID/EX-side signals of the decode stage.
// Handshake: IF presents if_valid; the instruction is taken on a posedge with if_valid & id_ready.
interface decode_stage_if #(
   parameter int XLEN     = 32,
   parameter int ALUSEL_W = 4,
   parameter int CNT_W    = 16
);
   logic                if_valid;
   logic [31:0]         if_instr;
   logic [XLEN-1:0]     if_pc;
   logic                id_ready;
   logic                flush;
   logic                ex_ready;
   logic                ex_valid;
   logic [XLEN-1:0]     ex_pc;
   logic [4:0]          ex_rs1;
   logic [4:0]          ex_rs2;
   logic [4:0]          ex_rd;
   logic [XLEN-1:0]     ex_imm;
   logic [ALUSEL_W-1:0] ex_alusel;
   logic                ex_use_imm;
   logic                ex_reg_write;
   logic                ex_mem_read;
   logic                ex_mem_write;
   logic                ex_branch;
   logic                ex_jump;
   logic                ex_jalr;
   logic                ex_illegal;
   logic [CNT_W-1:0]    stall_cnt;

   modport slave (
      input  if_valid, if_instr, if_pc, flush, ex_ready,
      output id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alusel,
             ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_jump, ex_jalr, ex_illegal, stall_cnt
   );

   modport master (
      output if_valid, if_instr, if_pc, flush, ex_ready,
      input  id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alusel,
             ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_jump, ex_jalr, ex_illegal, stall_cnt
   );
endinterface

// File: rtl/decode_comb.sv
// Combinational RV32I decoder: control bundle, sign-extended immediate and
// which source registers the instruction actually reads.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm,
   output logic            use_rs1,
   output logic            use_rs2
);
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       bad;
   imm_fmt_t   fmt;
   logic [31:0] imm32;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   always_comb begin
      ctrl    = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      fmt     = IMM_NONE;
      bad     = 1'b0;
      case (opcode)
         OP_R: begin
            bad = !((f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            ctrl.alusel    = alu_sel(f3, instr[30]);
            ctrl.reg_write = 1'b1;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         OP_IMM: begin
            // Only shifts constrain the upper immediate bits; SUB cannot arise here.
            if (f3 == 3'b001)      bad = (f7 != 7'b0000000);
            else if (f3 == 3'b101) bad = !(f7 == 7'b0000000 || f7 == 7'b0100000);
            ctrl.alusel    = alu_sel(f3, (f3 == 3'b101) & instr[30]);
            ctrl.reg_write = 1'b1;
            ctrl.use_imm   = 1'b1;
            use_rs1        = 1'b1;
            fmt            = IMM_I;
         end
         OP_LOAD: begin
            bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            ctrl.mem_read  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.use_imm   = 1'b1;
            use_rs1        = 1'b1;
            fmt            = IMM_I;
         end
         OP_STORE: begin
            bad = !(f3 inside {3'b000, 3'b001, 3'b010});
            ctrl.mem_write = 1'b1;
            ctrl.use_imm   = 1'b1;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
            fmt            = IMM_S;
         end
         OP_BRANCH: begin
            bad = (f3 == 3'b010 || f3 == 3'b011);
            ctrl.branch = 1'b1;
            ctrl.alusel = ALUSEL_SUB;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            fmt         = IMM_B;
         end
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
            fmt            = IMM_J;
         end
         OP_JALR: begin
            bad = (f3 != 3'b000);
            ctrl.jump      = 1'b1;
            ctrl.jalr      = 1'b1;
            ctrl.use_imm   = 1'b1;
            ctrl.reg_write = 1'b1;
            use_rs1        = 1'b1;
            fmt            = IMM_I;
         end
         OP_LUI, OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.use_imm   = 1'b1;
            fmt            = IMM_U;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
         use_rs1      = 1'b0;
         use_rs2      = 1'b0;
         fmt          = IMM_NONE;
      end
      if (instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
   end

   always_comb begin
      imm32 = '0;
      case (fmt)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'(signed'(imm32));
endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: decodes IF/ID, inserts one bubble per load-use hazard,
// honours flush, and holds the ID/EX register while EX back-pressures.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALUSEL_W = 4,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          rst_n,
   decode_stage_if.slave bus
);
   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;
   logic            use_rs1;
   logic            use_rs2;
   logic [4:0]      rs1, rs2, rd;
   logic            hazard;
   logic            advance;

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [XLEN-1:0] imm_q;
   ctrl_t           ctrl_q;
   logic [CNT_W-1:0] cnt_q;

   decode_comb #(.XLEN(XLEN)) u_decode_comb (
      .instr   (bus.if_instr),
      .ctrl    (dec_ctrl),
      .imm     (dec_imm),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2)
   );

   assign rs1 = bus.if_instr[19:15];
   assign rs2 = bus.if_instr[24:20];
   assign rd  = bus.if_instr[11:7];

   assign hazard  = bus.if_valid & valid_q & ctrl_q.mem_read & (rd_q != 5'd0) &
                    ((use_rs1 & (rs1 == rd_q)) | (use_rs2 & (rs2 == rd_q)));
   assign advance = bus.ex_ready | ~valid_q;
   assign bus.id_ready = advance & ~hazard & ~bus.flush;

   // Bubbles also clear the control bundle so a stale load never re-triggers a hazard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (advance) begin
         if (hazard) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         end else if (bus.if_valid) begin
            valid_q <= 1'b1;
            pc_q    <= bus.if_pc;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            imm_q   <= dec_imm;
            ctrl_q  <= dec_ctrl;
         end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
         end
      end
   end

   assign bus.ex_valid     = valid_q;
   assign bus.ex_pc        = pc_q;
   assign bus.ex_rs1       = rs1_q;
   assign bus.ex_rs2       = rs2_q;
   assign bus.ex_rd        = rd_q;
   assign bus.ex_imm       = imm_q;
   assign bus.ex_alusel    = ALUSEL_W'(ctrl_q.alusel);
   assign bus.ex_use_imm   = ctrl_q.use_imm;
   assign bus.ex_reg_write = ctrl_q.reg_write;
   assign bus.ex_mem_read  = ctrl_q.mem_read;
   assign bus.ex_mem_write = ctrl_q.mem_write;
   assign bus.ex_branch    = ctrl_q.branch;
   assign bus.ex_jump      = ctrl_q.jump;
   assign bus.ex_jalr      = ctrl_q.jalr;
   assign bus.ex_illegal   = ctrl_q.illegal;
   assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction checks, then randomized traffic
// compared every cycle against an instruction-level model of the stage.
module tb_decode_stage;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   decode_stage_if #(.XLEN(32)) bus ();
   decode_stage_if #(.XLEN(64)) bus64 ();

   decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

   assign bus64.if_valid = bus.if_valid;
   assign bus64.if_instr = bus.if_instr;
   assign bus64.if_pc    = {32'b0, bus.if_pc};
   assign bus64.flush    = bus.flush;
   assign bus64.ex_ready = bus.ex_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  alu;
      logic        use_imm, reg_write, mem_read, mem_write, branch, jump, jalr, illegal;
      logic        use_rs1, use_rs2;
      logic [63:0] imm;
   } exp_t;

   // Reference decode straight from the ISA tables; imm is built at 64 bits.
   function automatic exp_t ref_decode(input logic [31:0] i);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      logic ok;
      logic [7:0] load_f3, store_f3, br_f3;
      e = '0; ok = 1'b1;
      f3 = i[14:12]; f7 = i[31:25];
      load_f3 = 8'b0011_0111; store_f3 = 8'b0000_0111; br_f3 = 8'b1111_0011;
      case (i[6:0])
         7'h33: begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.alu = alu_of(f3, f7 == 7'h20);
            e.reg_write = 1; e.use_rs1 = 1; e.use_rs2 = 1;
         end
         7'h13: begin
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
            e.alu = alu_of(f3, f3 == 3'd5 && f7 == 7'h20);
            e.reg_write = 1; e.use_imm = 1; e.use_rs1 = 1;
            e.imm = {{52{i[31]}}, i[31:20]};
         end
         7'h03: begin
            ok = load_f3[f3];
            e.mem_read = 1; e.reg_write = 1; e.use_imm = 1; e.use_rs1 = 1;
            e.imm = {{52{i[31]}}, i[31:20]};
         end
         7'h23: begin
            ok = store_f3[f3];
            e.mem_write = 1; e.use_imm = 1; e.use_rs1 = 1; e.use_rs2 = 1;
            e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
         end
         7'h63: begin
            ok = br_f3[f3];
            e.branch = 1; e.alu = 4'b0010; e.use_rs1 = 1; e.use_rs2 = 1;
            e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         end
         7'h6F: begin
            e.jump = 1; e.reg_write = 1;
            e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         end
         7'h67: begin
            ok = (f3 == 3'd0);
            e.jump = 1; e.jalr = 1; e.use_imm = 1; e.reg_write = 1; e.use_rs1 = 1;
            e.imm = {{52{i[31]}}, i[31:20]};
         end
         7'h37, 7'h17: begin
            e.reg_write = 1; e.use_imm = 1;
            e.imm = {{32{i[31]}}, i[31:12], 12'b0};
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin e = '0; e.illegal = 1; end
      if (i[11:7] == 5'd0) e.reg_write = 0;
      return e;
   endfunction

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? 4'b0010 : 4'b0000;
         3'd1: return 4'b0001;
         3'd2: return 4'b1000;
         3'd3: return 4'b1001;
         3'd4: return 4'b0100;
         3'd5: return alt ? 4'b0011 : 4'b0101;
         3'd6: return 4'b0110;
         default: return 4'b0111;
      endcase
   endfunction

   // Model state: which instruction sits in ID/EX, not its decoded bits.
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = 32'b0;
   logic [31:0] m_pc    = 32'b0;
   logic [15:0] m_cnt   = 16'b0;

   function automatic logic model_hazard();
      exp_t ex_e, if_e;
      logic [4:0] ld_rd;
      ex_e  = ref_decode(m_instr);
      if_e  = ref_decode(bus.if_instr);
      ld_rd = m_instr[11:7];
      return bus.if_valid && m_valid && ex_e.mem_read && ld_rd != 0 &&
             ((if_e.use_rs1 && bus.if_instr[19:15] == ld_rd) ||
              (if_e.use_rs2 && bus.if_instr[24:20] == ld_rd));
   endfunction

   function automatic logic model_ready();
      return (bus.ex_ready || !m_valid) && !model_hazard() && !bus.flush;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_cnt   <= 16'd0;
      end else if (bus.if_valid && model_ready()) begin
         m_valid <= 1'b1;
         m_instr <= bus.if_instr;
         m_pc    <= bus.if_pc;
      end else begin
         if (bus.flush || bus.ex_ready || !m_valid) m_valid <= 1'b0;
         if (!bus.flush && (bus.ex_ready || !m_valid) && model_hazard() && m_cnt != 16'hFFFF)
            m_cnt <= m_cnt + 16'd1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      e = ref_decode(m_instr);
      chk("id_ready", bus.id_ready, model_ready());
      chk("ex_valid", bus.ex_valid, m_valid);
      chk("stall_cnt", bus.stall_cnt, m_cnt);
      if (m_valid) begin
         chk("ex_pc", bus.ex_pc, m_pc);
         chk("ex_regs", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {m_instr[19:15], m_instr[24:20], m_instr[11:7]});
         chk("ex_imm", bus.ex_imm, e.imm[31:0]);
         chk("ex_alusel", bus.ex_alusel, e.alu);
         chk("ex_flags",
             {bus.ex_use_imm, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
              bus.ex_branch, bus.ex_jump, bus.ex_jalr, bus.ex_illegal},
             {e.use_imm, e.reg_write, e.mem_read, e.mem_write, e.branch, e.jump, e.jalr, e.illegal});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
      bus.if_valid = 1'b1;
      bus.if_instr = instr;
      bus.if_pc    = pc;
      step();
      bus.if_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [4:0] rd, rs1, rs2;
      int k;
      k   = $urandom_range(0, 11);
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0, 1:    f7 = 7'h00;
         2:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      case (k)
         0:       op = 7'h33;
         1, 11:   op = 7'h13;
         2, 3:    op = 7'h03;
         4:       op = 7'h23;
         5:       op = 7'h63;
         6:       op = 7'h6F;
         7:       op = 7'h67;
         8:       op = 7'h37;
         9:       op = 7'h17;
         default: op = 7'($urandom);
      endcase
      if (k == 3) f3 = 3'b010;
      if (k >= 2) f7 = 7'($urandom);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      bus.if_valid = 1'b0; bus.if_instr = 32'b0; bus.if_pc = 32'b0;
      bus.flush = 1'b0; bus.ex_ready = 1'b1;
      step(); step();
      chk("rst_ex_valid", bus.ex_valid, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_id_ready", bus.id_ready, 1);
      rst_n = 1'b1;

      issue(32'h002081B3, 32'h100);
      chk("add_valid", bus.ex_valid, 1);
      chk("add_alusel", bus.ex_alusel, 4'b0000);
      chk("add_rd", bus.ex_rd, 3);
      chk("add_reg_write", bus.ex_reg_write, 1);
      chk("add_imm", bus.ex_imm, 0);

      issue(32'h0080A283, 32'h104);
      bus.if_valid = 1'b1; bus.if_instr = 32'h00228333; bus.if_pc = 32'h108;
      #1;
      chk("lu_id_ready", bus.id_ready, 0);
      chk("lu_cnt_before", bus.stall_cnt, 0);
      step();
      chk("lu_bubble", bus.ex_valid, 0);
      chk("lu_cnt_after", bus.stall_cnt, 1);
      #1;
      chk("lu_ready_again", bus.id_ready, 1);
      step();
      bus.if_valid = 1'b0;
      chk("lu_add_valid", bus.ex_valid, 1);
      chk("lu_add_rd", bus.ex_rd, 6);

      issue(32'hFE20AE23, 32'h10C);
      chk("sw_mem_write", bus.ex_mem_write, 1);
      chk("sw_reg_write", bus.ex_reg_write, 0);
      chk("sw_imm", bus.ex_imm, 32'hFFFFFFFC);

      issue(32'hFE000CE3, 32'h110);
      chk("beq_branch", bus.ex_branch, 1);
      chk("beq_alusel", bus.ex_alusel, 4'b0010);
      chk("beq_imm", bus.ex_imm, 32'hFFFFFFF8);
      chk("beq_imm64", bus64.ex_imm, 64'hFFFFFFFFFFFFFFF8);

      issue(32'h002081B3, 32'h200);
      bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_instr = 32'h00000013; bus.if_pc = 32'h204;
      #1;
      chk("hold_id_ready", bus.id_ready, 0);
      step();
      chk("hold_valid", bus.ex_valid, 1);
      chk("hold_pc", bus.ex_pc, 32'h200);
      chk("hold_rd", bus.ex_rd, 3);
      bus.flush = 1'b1;
      step();
      chk("flush_valid", bus.ex_valid, 0);
      bus.flush = 1'b0; bus.if_valid = 1'b0;
      step();
      bus.ex_ready = 1'b1;

      issue(32'h0000007F, 32'h300);
      chk("ill_flag", bus.ex_illegal, 1);
      chk("ill_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                       bus.ex_branch, bus.ex_jump, bus.ex_jalr}, 0);
      issue(32'h00208033, 32'h304);
      chk("rd0_reg_write", bus.ex_reg_write, 0);
      chk("rd0_illegal", bus.ex_illegal, 0);

      for (int n = 0; n < 400; n++) begin
         if (n == 200) rst_n = 1'b0;
         bus.if_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 || !bus.if_valid) bus.if_instr = rand_instr();
         bus.if_pc    = $urandom & 32'hFFFF_FFFC;
         bus.ex_ready = ($urandom_range(0, 3) != 0);
         bus.flush    = ($urandom_range(0, 15) == 0);
         step();
         if (n == 200) begin
            chk("midrst_valid", bus.ex_valid, 0);
            chk("midrst_cnt", bus.stall_cnt, 0);
            rst_n = 1'b1;
         end
      end
      bus.if_valid = 1'b0; bus.flush = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
